// File: rtl/alu_md_pkg.sv
// Shared constants for the alu_md execute unit: ALUOp encodings, R-type
// function codes and the mul/div sequencer state type.
package alu_md_pkg;

  localparam logic [1:0] ALUOP_ADD     = 2'b00;
  localparam logic [1:0] ALUOP_SUB     = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT   = 2'b10;
  localparam logic [1:0] ALUOP_ILLEGAL = 2'b11;

  localparam logic [5:0] FN_SLL   = 6'b000000;
  localparam logic [5:0] FN_SRL   = 6'b000010;
  localparam logic [5:0] FN_SRA   = 6'b000011;
  localparam logic [5:0] FN_SLLV  = 6'b000100;
  localparam logic [5:0] FN_SRLV  = 6'b000110;
  localparam logic [5:0] FN_SRAV  = 6'b000111;
  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MTHI  = 6'b010001;
  localparam logic [5:0] FN_MFLO  = 6'b010010;
  localparam logic [5:0] FN_MTLO  = 6'b010011;
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_DIVU  = 6'b011011;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_XOR   = 6'b100110;
  localparam logic [5:0] FN_NOR   = 6'b100111;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  localparam logic [5:0] FN_SLTU  = 6'b101011;

  // Mul/div sequencer: IDLE -> MUL|DIV (DATA_W steps) -> DONE -> IDLE
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } md_state_t;

endpackage

// File: rtl/alu_md_iter.sv
// Iterative multiply/divide datapath: magnitude conversion at start,
// one shift-add or restoring-divide step per cycle, sign fix-up in DONE.
// Handshake: start is honoured only in IDLE; done is high for the single
// DONE cycle, during which hi/lo carry the final signed-corrected values.
module alu_md_iter
  import alu_md_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              is_div,
  input  logic              is_signed,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              done,
  output logic              busy,
  output md_state_t         state,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  logic [CNT_W-1:0]    cnt;
  logic [DATA_W-1:0]   opnd;
  logic [DATA_W-1:0]   a_orig;
  logic [2*DATA_W-1:0] acc;
  logic                op_div;
  logic                neg_q;
  logic                neg_r;
  logic                div_zero;

  logic              a_neg;
  logic              b_neg;
  logic [DATA_W-1:0] a_mag;
  logic [DATA_W-1:0] b_mag;
  logic [DATA_W:0]   mul_sum;
  logic [DATA_W:0]   div_shift;
  logic [DATA_W:0]   div_diff;

  assign a_neg = is_signed & a[DATA_W-1];
  assign b_neg = is_signed & b[DATA_W-1];
  assign a_mag = a_neg ? -a : a;
  assign b_mag = b_neg ? -b : b;

  // acc holds {partial product, multiplier} for MUL and {remainder, quotient} for DIV
  assign mul_sum   = {1'b0, acc[2*DATA_W-1:DATA_W]} + (acc[0] ? {1'b0, opnd} : '0);
  assign div_shift = acc[2*DATA_W-1:DATA_W-1];
  assign div_diff  = div_shift - {1'b0, opnd};

  // Sequencer and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      busy     <= 1'b0;
      cnt      <= '0;
      opnd     <= '0;
      a_orig   <= '0;
      acc      <= '0;
      op_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            busy     <= 1'b1;
            cnt      <= '0;
            a_orig   <= a;
            op_div   <= is_div;
            neg_q    <= a_neg ^ b_neg;
            neg_r    <= a_neg;
            div_zero <= is_div && (b == '0);
            if (is_div) begin
              opnd  <= b_mag;
              acc   <= {{DATA_W{1'b0}}, a_mag};
              state <= ST_DIV;
            end else begin
              opnd  <= a_mag;
              acc   <= {{DATA_W{1'b0}}, b_mag};
              state <= ST_MUL;
            end
          end
        end
        ST_MUL: begin
          acc <= {mul_sum, acc[DATA_W-1:1]};
          cnt <= cnt + 1'b1;
          if (cnt == CNT_LAST) state <= ST_DONE;
        end
        ST_DIV: begin
          if (!div_diff[DATA_W]) acc <= {div_diff[DATA_W-1:0], acc[DATA_W-2:0], 1'b1};
          else                   acc <= {div_shift[DATA_W-1:0], acc[DATA_W-2:0], 1'b0};
          cnt <= cnt + 1'b1;
          if (cnt == CNT_LAST) state <= ST_DONE;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign done = (state == ST_DONE);

  logic [2*DATA_W-1:0] prod_neg;
  assign prod_neg = -acc;

  // Sign fix-up; divide-by-zero returns all ones and the untouched dividend
  always_comb begin
    hi = acc[2*DATA_W-1:DATA_W];
    lo = acc[DATA_W-1:0];
    if (!op_div) begin
      if (neg_q) {hi, lo} = prod_neg;
    end else if (div_zero) begin
      hi = a_orig;
      lo = '1;
    end else begin
      if (neg_q) lo = -acc[DATA_W-1:0];
      if (neg_r) hi = -acc[2*DATA_W-1:DATA_W];
    end
  end

endmodule

// File: rtl/alu_md.sv
// Registered execute-stage ALU with optional iterative mul/div and HI/LO.
// Handshake: an op transfers when in_valid && in_ready; in_ready is high
// only while the mul/div sequencer is idle. Results appear as a one-cycle
// out_valid pulse with no output backpressure.
module alu_md
  import alu_md_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter bit MD_EN  = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        alu_op,
  input  logic [5:0]        funct,
  input  logic [DATA_W-1:0] operand_a,
  input  logic [DATA_W-1:0] operand_b,
  output logic              out_valid,
  output logic [DATA_W-1:0] result,
  output logic              zero,
  output logic              overflow,
  output logic              illegal,
  output logic              busy
);

  localparam int SH_W = $clog2(DATA_W);

  logic [5:0]        fn;
  logic              op_bad;
  logic [DATA_W-1:0] sum;
  logic [DATA_W-1:0] dif;
  logic [SH_W-1:0]   shamt;
  logic [DATA_W-1:0] alu_res;
  logic              alu_ovf;
  logic              alu_ill;
  logic              md_op;
  logic              hi_wr;
  logic              lo_wr;
  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] lo;
  logic              accept;
  logic              md_start;
  logic              md_done;
  logic              md_busy;
  md_state_t         md_state;
  logic [DATA_W-1:0] md_hi;
  logic [DATA_W-1:0] md_lo;

  // ALUOp decode to an effective function code
  always_comb begin
    fn     = funct;
    op_bad = 1'b0;
    case (alu_op)
      ALUOP_ADD:     fn = FN_ADD;
      ALUOP_SUB:     fn = FN_SUB;
      ALUOP_FUNCT:   fn = funct;
      ALUOP_ILLEGAL: op_bad = 1'b1;
      default:       op_bad = 1'b1;
    endcase
  end

  assign sum   = operand_a + operand_b;
  assign dif   = operand_a - operand_b;
  assign shamt = operand_b[SH_W-1:0];

  // Single-cycle result, flags and HI/LO/mul-div side effects
  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    alu_ill = 1'b0;
    md_op   = 1'b0;
    hi_wr   = 1'b0;
    lo_wr   = 1'b0;
    case (fn)
      FN_ADD: begin
        alu_res = sum;
        alu_ovf = (operand_a[DATA_W-1] == operand_b[DATA_W-1]) &&
                  (sum[DATA_W-1] != operand_a[DATA_W-1]);
      end
      FN_ADDU: alu_res = sum;
      FN_SUB: begin
        alu_res = dif;
        alu_ovf = (operand_a[DATA_W-1] != operand_b[DATA_W-1]) &&
                  (dif[DATA_W-1] != operand_a[DATA_W-1]);
      end
      FN_SUBU: alu_res = dif;
      FN_AND:  alu_res = operand_a & operand_b;
      FN_OR:   alu_res = operand_a | operand_b;
      FN_XOR:  alu_res = operand_a ^ operand_b;
      FN_NOR:  alu_res = ~(operand_a | operand_b);
      FN_SLT:  alu_res = {{(DATA_W-1){1'b0}}, $signed(operand_a) < $signed(operand_b)};
      FN_SLTU: alu_res = {{(DATA_W-1){1'b0}}, operand_a < operand_b};
      FN_SLL, FN_SLLV: alu_res = operand_a << shamt;
      FN_SRL, FN_SRLV: alu_res = operand_a >> shamt;
      FN_SRA, FN_SRAV: alu_res = $signed(operand_a) >>> shamt;
      FN_MFHI: begin
        alu_res = hi;
        alu_ill = !MD_EN;
      end
      FN_MFLO: begin
        alu_res = lo;
        alu_ill = !MD_EN;
      end
      FN_MTHI: begin
        alu_res = operand_a;
        hi_wr   = MD_EN;
        alu_ill = !MD_EN;
      end
      FN_MTLO: begin
        alu_res = operand_a;
        lo_wr   = MD_EN;
        alu_ill = !MD_EN;
      end
      FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: begin
        md_op   = MD_EN;
        alu_ill = !MD_EN;
      end
      default: alu_ill = 1'b1;
    endcase
    if (op_bad || alu_ill) begin
      alu_ill = 1'b1;
      alu_res = '1;
      alu_ovf = 1'b0;
      md_op   = 1'b0;
      hi_wr   = 1'b0;
      lo_wr   = 1'b0;
    end
  end

  assign in_ready = (md_state == ST_IDLE);
  assign accept   = in_valid && in_ready;
  assign md_start = accept && md_op;
  assign busy     = md_busy;

  if (MD_EN) begin : g_md
    alu_md_iter #(.DATA_W(DATA_W)) u_iter (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (md_start),
      .is_div    (fn[1]),
      .is_signed (~fn[0]),
      .a         (operand_a),
      .b         (operand_b),
      .done      (md_done),
      .busy      (md_busy),
      .state     (md_state),
      .hi        (md_hi),
      .lo        (md_lo)
    );
  end else begin : g_no_md
    assign md_done  = 1'b0;
    assign md_busy  = 1'b0;
    assign md_state = ST_IDLE;
    assign md_hi    = '0;
    assign md_lo    = '0;
  end

  // Output registers and HI/LO; single-cycle ops and mul/div completion never coincide
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b1;
      overflow  <= 1'b0;
      illegal   <= 1'b0;
      hi        <= '0;
      lo        <= '0;
    end else begin
      out_valid <= 1'b0;
      if (accept && !md_op) begin
        out_valid <= 1'b1;
        result    <= alu_res;
        zero      <= (alu_res == '0);
        overflow  <= alu_ovf;
        illegal   <= alu_ill;
        if (hi_wr) hi <= operand_a;
        if (lo_wr) lo <= operand_a;
      end else if (md_done) begin
        out_valid <= 1'b1;
        result    <= md_lo;
        zero      <= (md_lo == '0);
        overflow  <= 1'b0;
        illegal   <= 1'b0;
        hi        <= md_hi;
        lo        <= md_lo;
      end
    end
  end

endmodule

// File: doc/alu_md.md
Name: alu_md

Overview:
- Parametrised-width, registered successor to the single-cycle execute-stage ALU.
- Keeps the ALUOp/funct decode and the R-type operation set, with correct shifts and signed-overflow detection.
- Adds an iterative multiply/divide unit with HI/LO registers: MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI, MTLO.
- Uses a valid/ready handshake so the pipeline stalls while a multi-cycle op runs.

Parameters:
- DATA_W, 32: operand/result width; must be a power of two, at least 8.
- MD_EN, 1: 1 instantiates the mul/div unit and HI/LO; 0 makes all mul/div/HI/LO functs illegal.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous reset, active low
- in_valid  in  1  operation presented
- in_ready  out  1  block can accept; transfer when in_valid && in_ready
- alu_op  in  2  00 force ADD, 01 force SUB, 10 use funct, 11 illegal
- funct  in  6  R-type function code
- operand_a  in  DATA_W  rs operand / shift source
- operand_b  in  DATA_W  rt operand / shift amount (low log2(DATA_W) bits)
- out_valid  out  1  one-cycle pulse: result/flags valid
- result  out  DATA_W  registered result; held between pulses
- zero  out  1  result == 0, registered with result
- overflow  out  1  signed overflow on ADD/SUB only
- illegal  out  1  undecoded op; result = all ones
- busy  out  1  mul/div iteration in progress

Behaviour:
- Reset, asynchronous:
  - result=0, zero=1, overflow=0, illegal=0, out_valid=0, busy=0.
  - HI=0, LO=0, state=IDLE, counter=0.
  - Reset mid-iteration abandons the op; no out_valid.
- Decode:
  - alu_op 00 -> 100000; 01 -> 100010; 10 -> funct; 11 -> illegal.
- Single-cycle ops, latency 1 (accepted in cycle N, out_valid in N+1):
  - ADD/ADDU/SUB/SUBU: modulo 2^DATA_W.
  - Overflow flag set only for ADD/SUB on signed overflow; the result is still written.
  - AND/OR/XOR/NOR; SLT signed; SLTU unsigned.
  - SLL/SLLV: logical left. SRL/SRLV: logical right. SRA/SRAV: arithmetic right.
  - Shift amount is always operand_b[log2(DATA_W)-1:0].
  - MFHI/MFLO: result = HI/LO.
  - MTHI/MTLO: HI/LO = operand_a; result = operand_a.
- Unknown funct: illegal=1, result all ones, latency 1.
- in_ready = (state==IDLE). Only one op is in flight; there is no output backpressure.
- FSM IDLE -> MUL or DIV -> DONE -> IDLE:
  - Accept MULT(U)/DIV(U) in IDLE: latch operands, busy=1, counter=0.
  - Signed variants first take magnitudes and record the result signs.
  - MUL: shift-add, one bit per cycle, DATA_W cycles; 2*DATA_W-bit product.
  - DIV: restoring division, one quotient bit per cycle, DATA_W cycles.
  - DONE (1 cycle): apply signs.
    - Product is negated if the operand signs differ.
    - Quotient is negated if the signs differ; remainder takes the dividend's sign.
    - Write HI (product high / remainder) and LO (product low / quotient).
  - Next cycle: out_valid=1, result=LO, busy=0, state=IDLE.
  - Total latency: DATA_W+2 cycles from accept to out_valid.
- Divide by zero:
  - Full DATA_W iterations still run.
  - LO = all ones; HI = dividend (signed: the original signed value).
  - No flag.
- Most-negative / -1 (DIV): LO = most-negative value, HI = 0.
- Simultaneous events:
  - in_valid while busy is not accepted; in_ready=0.
  - An op may be accepted in the cycle out_valid pulses.
- zero and overflow are cleared on every out_valid except where stated; illegal is cleared on legal ops.

Decomposition:
- Package alu_md_pkg:
  - ALUOp constants.
  - Funct constants, including 010000–010011 (MFHI/MTHI/MFLO/MTLO) and 011000–011011 (MULT/MULTU/DIV/DIVU).
  - FSM state enum.
- Sub-module alu_md_iter: the shift-add/restoring datapath with its counter, start/done handshake and signed fix-up.
- The top holds decode, combinational ALU, HI/LO, and output registers.

Test Plan (DATA_W=32):
- ADD 0x7FFFFFFF+1 via alu_op=00 -> out_valid next cycle, result 0x80000000, overflow=1. Same operands with ADDU -> overflow=0.
- SRA a=0x80000000, b=0x00000024 (amount 4) -> 0xF8000000. SRL same -> 0x08000000. SUB 5-5 -> result 0, zero=1.
- MULT a=-3, b=7:
  - in_ready=0 for 33 cycles; out_valid at accept+34.
  - HI=0xFFFFFFFF, LO=0xFFFFFFEB.
  - MFHI then returns 0xFFFFFFFF.
- DIV a=-7, b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU a=7, b=0 -> LO=0xFFFFFFFF, HI=7.
- in_valid held high during a DIVU -> not accepted until in_ready returns; the following ADD is accepted in the out_valid cycle.
- rst_n pulsed low at iteration 10 of MULTU -> busy=0, HI=LO=0, no out_valid. funct=111111 afterwards -> illegal=1, result 0xFFFFFFFF.
